// File: rtl/mux4_arbiter.sv
// Round-robin arbiter driving the select and one-hot grant of a shared 4-input mux.
// Optional forced-revoke hold limit enabled by defining ARB_TIMEOUT_EN.
module mux4_arbiter #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        REL   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state, state_nxt;
    logic [1:0]       last, last_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_nxt;
    logic [3:0]       grant_nxt;
    logic [1:0]       sel_nxt;
    logic             busy_nxt;
    logic             timeout_nxt;
    logic [1:0]       winner_c;
    logic             found_c;
    logic             to_en_c;
    logic             release_c;
    logic             force_c;

`ifdef ARB_TIMEOUT_EN
    assign to_en_c = 1'b1;
`else
    assign to_en_c = 1'b0;
`endif

    // Round-robin search starting one past the last owner, wrapping 3->0.
    always_comb begin
        logic [1:0] cand;
        found_c  = 1'b0;
        winner_c = last;
        cand     = last;
        for (int i = 1; i <= 4; i++) begin
            cand = last + 2'(i);
            if (!found_c && req[cand]) begin
                found_c  = 1'b1;
                winner_c = cand;
            end
        end
    end

    assign release_c = done || !req[sel];
    assign force_c   = to_en_c && (hold_cnt == HOLD_LAST);

    always_comb begin
        state_nxt   = state;
        last_nxt    = last;
        hold_nxt    = hold_cnt;
        grant_nxt   = 4'b0000;
        sel_nxt     = sel;
        busy_nxt    = 1'b0;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (found_c) begin
                    state_nxt = GRANT;
                    grant_nxt = 4'(1) << winner_c;
                    sel_nxt   = winner_c;
                    last_nxt  = winner_c;
                    busy_nxt  = 1'b1;
                    hold_nxt  = '0;
                end
            end
            GRANT: begin
                // A normal release wins over the hold limit, so no pulse then.
                if (release_c) begin
                    state_nxt = REL;
                end else if (force_c) begin
                    state_nxt   = REL;
                    timeout_nxt = 1'b1;
                end else begin
                    grant_nxt = grant;
                    busy_nxt  = 1'b1;
                    if (hold_cnt != '1) begin
                        hold_nxt = hold_cnt + CNT_W'(1);
                    end
                end
            end
            REL:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= 2'd3;
            hold_cnt <= '0;
            grant    <= 4'b0000;
            sel      <= 2'b00;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            hold_cnt <= hold_nxt;
            grant    <= grant_nxt;
            sel      <= sel_nxt;
            busy     <= busy_nxt;
            timeout  <= timeout_nxt;
        end
    end

endmodule
